// File: rtl/j4_slot_supervisor_if.sv
// rtl/j4_slot_supervisor_if.sv - core I/O bus as seen by the slot supervisor
interface j4_slot_supervisor_if;
    logic        io_rd;
    logic        io_wr;
    logic [1:0]  io_slot;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] rd_data;

    modport master (
        output io_rd, io_wr, io_slot, mem_addr, dout,
        input  rd_data
    );

    modport slave (
        input  io_rd, io_wr, io_slot, mem_addr, dout,
        output rd_data
    );
endinterface

// File: rtl/j4_slot_supervisor.sv
// rtl/j4_slot_supervisor.sv - 4-slot restart control, per-slot watchdog, fault status, SLOTID
// Optional write protection (CTRL/STAT from slot 0 only, STAT[15] viol) under J4_SUPERVISOR_PROTECT_EN.
module j4_slot_supervisor #(
    parameter logic [15:0]      BASE    = 16'h0100,
    parameter int               WDT_W   = 16,
    parameter logic [WDT_W-1:0] WDT_RLD = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    j4_slot_supervisor_if.slave   bus,
    output logic [3:0]            kill_slot_rq
);

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PET    = 2'd1;
    localparam logic [1:0] OFF_STAT   = 2'd2;
    localparam logic [1:0] OFF_SLOTID = 2'd3;

    logic [3:0]       kill_q, kill_d;
    logic [3:0]       wdt_en_q, wdt_en_d;
    logic [3:0]       fired_q, fired_d;
    logic [WDT_W-1:0] cnt_q [4];
    logic [WDT_W-1:0] cnt_d [4];
    logic             viol_q, viol_d;

    logic       sel, wr_en, wr_allow;
    logic [1:0] off;
    logic [3:0] restart, pet, stat_clr, fire;
    logic [15:0] rd_data_c;

    assign off   = bus.mem_addr[2:1];
    assign sel   = (bus.io_rd | bus.io_wr) & (bus.mem_addr[15:3] == BASE[15:3]);
    assign wr_en = sel & bus.io_wr;

`ifdef J4_SUPERVISOR_PROTECT_EN
    assign wr_allow = (bus.io_slot == 2'd0);
`else
    assign wr_allow = 1'b1;
`endif

    always_comb begin
        wdt_en_d = wdt_en_q;
        restart  = '0;
        pet      = '0;
        stat_clr = '0;
        fire     = '0;
        viol_d   = 1'b0;

        if (wr_en && off == OFF_CTRL && wr_allow) begin
            wdt_en_d = bus.dout[11:8];
            restart  = bus.dout[3:0];
        end
        if (wr_en && off == OFF_PET) begin
            pet = 4'b0001 << bus.io_slot;
        end
        if (wr_en && off == OFF_STAT && wr_allow) begin
            stat_clr = bus.dout[7:4];
        end

        // A disabled counter sits at WDT_RLD, so a 0->1 enable always starts from a full count.
        // PET beats expiry; a restart does not suppress the fire, it only merges the pulse.
        for (int s = 0; s < 4; s++) begin
            fire[s] = wdt_en_q[s] && (cnt_q[s] == '0) && !pet[s];
            if (!wdt_en_q[s] || pet[s] || restart[s] || fire[s]) begin
                cnt_d[s] = WDT_RLD;
            end else begin
                cnt_d[s] = cnt_q[s] - 1'b1;
            end
        end

        kill_d  = fire | restart;
        fired_d = (fired_q & ~stat_clr) | fire;

`ifdef J4_SUPERVISOR_PROTECT_EN
        viol_d = viol_q;
        if (wr_en && off == OFF_STAT && wr_allow && bus.dout[15]) begin
            viol_d = 1'b0;
        end
        if (wr_en && (off == OFF_CTRL || off == OFF_STAT) && !wr_allow) begin
            viol_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kill_q   <= '0;
            wdt_en_q <= '0;
            fired_q  <= '0;
            viol_q   <= 1'b0;
            for (int s = 0; s < 4; s++) begin
                cnt_q[s] <= WDT_RLD;
            end
        end else begin
            kill_q   <= kill_d;
            wdt_en_q <= wdt_en_d;
            fired_q  <= fired_d;
            viol_q   <= viol_d;
            for (int s = 0; s < 4; s++) begin
                cnt_q[s] <= cnt_d[s];
            end
        end
    end

    // Read data must be valid in the io_rd cycle itself; the core OR-muxes it into io_din.
    always_comb begin
        rd_data_c = '0;
        if (sel && bus.io_rd) begin
            case (off)
                OFF_CTRL:   rd_data_c = {4'b0, wdt_en_q, 8'b0};
                OFF_PET:    rd_data_c = '0;
                OFF_STAT:   rd_data_c = {viol_q, 7'b0, fired_q, wdt_en_q};
                OFF_SLOTID: rd_data_c = {14'b0, bus.io_slot};
                default:    rd_data_c = '0;
            endcase
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign kill_slot_rq = kill_q;

endmodule
